// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state and address-width helper for the M1 read/write blocks
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Per-bank address width for an m x m matrix striped across n banks.
  function automatic int addr_width(input int m, input int n);
    return (((m * m) / n) > 1) ? $clog2((m * m) / n) : 1;
  endfunction

endpackage

// File: rtl/mem_write_m1.sv
// rtl/mem_write_m1.sv - streams a row-major M x M matrix into N column-striped BRAM banks
module mem_write_m1
  import mem_pkg::*;
#(
  parameter int D_W = 8,
  parameter int N   = 3,
  parameter int M   = 6,
  localparam int AW = addr_width(M, N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic [D_W-1:0] in_data,
  output logic           in_ready,
  output logic [AW-1:0]  wr_addr_bram [N-1:0],
  output logic [D_W-1:0] wr_data_bram [N-1:0],
  output logic [N-1:0]   wr_en_bram,
  output logic           busy,
  output logic           done
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  generate
    if (M % N != 0) begin : g_bad_cfg
      $error("mem_write_m1: M must be a multiple of N");
    end
  endgenerate

  mem_state_e    state, state_nxt;
  logic [CW-1:0] row, row_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [N-1:0]  wr_en_nxt;
  logic [AW-1:0] addr_nxt;
  int            bank;

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Column c lives in bank c % N; each bank holds M/N columns stacked M rows deep.
  always_comb begin
    bank     = int'(col) % N;
    addr_nxt = AW'(((int'(col) / N) * M) + int'(row));
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    wr_en_nxt = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          for (int b = 0; b < N; b++) begin
            if (bank == b) wr_en_nxt[b] = 1'b1;
          end
          if (col == LAST) begin
            col_nxt = '0;
            if (row == LAST) begin
              row_nxt   = '0;
              state_nxt = DONE;
            end else begin
              row_nxt = row + 1'b1;
            end
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        row_nxt   = '0;
        col_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      wr_en_bram <= '0;
      for (int b = 0; b < N; b++) begin
        wr_addr_bram[b] <= '0;
        wr_data_bram[b] <= '0;
      end
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      col        <= col_nxt;
      wr_en_bram <= wr_en_nxt;
      for (int b = 0; b < N; b++) begin
        if (wr_en_nxt[b]) begin
          wr_addr_bram[b] <= addr_nxt;
          wr_data_bram[b] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_m1.sv
// tb/tb_mem_write_m1.sv - directed self-checking bench for mem_write_m1 (N=3, M=6, D_W=8)
module tb_mem_write_m1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] wr_addr_bram [2:0];
  logic [7:0] wr_data_bram [2:0];
  logic [2:0] wr_en_bram;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int done_count = 0;
  int base_w;
  int base_d;
  logic [7:0] mem [3][16];

  mem_write_m1 #(.D_W(8), .N(3), .M(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .wr_addr_bram (wr_addr_bram),
    .wr_data_bram (wr_data_bram),
    .wr_en_bram   (wr_en_bram),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // BRAM model: captures whatever the writer presents, mid-cycle.
  always @(negedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (wr_en_bram[b] === 1'b1) begin
        wr_count++;
        mem[b][wr_addr_bram[b]] = wr_data_bram[b];
      end
    end
    if (done === 1'b1) done_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Beat k of a load is element (k/6, k%6): bank (k%6)%3, address ((k%6)/3)*6 + k/6.
  task automatic beat(input int k, input logic [7:0] d);
    int b;
    b = (k % 6) % 3;
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    chk("beat_wr_en", 32'(wr_en_bram), 32'(1) << b);
    chk("beat_addr", 32'(wr_addr_bram[b]), ((k % 6) / 3) * 6 + k / 6);
    chk("beat_data", 32'(wr_data_bram[b]), 32'(d));
    chk("beat_done", 32'(done), (k == 35) ? 1 : 0);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(wr_en_bram), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Idle with in_valid high: nothing must happen.
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_wr_en", 32'(wr_en_bram), 0);
      chk("idle_done", 32'(done), 0);
    end
    in_valid = 1'b0;
    chk("idle_writes", 32'(wr_count), 0);

    // Full back-to-back load, data = beat index; start pulsed mid-load.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_in_ready", 32'(in_ready), 1);
    chk("load_busy", 32'(busy), 1);
    base_w = wr_count;
    base_d = done_count;
    for (int k = 0; k < 36; k++) begin
      if (k == 20) start = 1'b1;
      beat(k, 8'(k));
      start = 1'b0;
    end
    chk("done_in_ready", 32'(in_ready), 0);
    chk("done_busy", 32'(busy), 1);
    @(posedge clk); #1;
    chk("post_busy", 32'(busy), 0);
    chk("post_done", 32'(done), 0);
    chk("post_wr_en", 32'(wr_en_bram), 0);
    chk("post_in_ready", 32'(in_ready), 0);
    chk("load_writes", 32'(wr_count - base_w), 36);
    chk("load_dones", 32'(done_count - base_d), 1);

    // Read-back: bank b, address c*6+r holds A[r][3c+b] = r*6 + 3c + b.
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 2; c++)
        for (int r = 0; r < 6; r++)
          chk("readback", 32'(mem[b][c * 6 + r]), r * 6 + 3 * c + b);

    // Load with a 3-cycle gap after beat 4.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_w = wr_count;
    base_d = done_count;
    for (int k = 0; k < 36; k++) begin
      beat(k, 8'(k + 100));
      if (k == 4) begin
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0;
          in_data  = 8'hEE;
          @(posedge clk); #1;
          chk("gap_wr_en", 32'(wr_en_bram), 0);
          chk("gap_in_ready", 32'(in_ready), 1);
        end
      end
    end
    @(posedge clk); #1;
    chk("gap_post_busy", 32'(busy), 0);
    chk("gap_writes", 32'(wr_count - base_w), 36);
    chk("gap_dones", 32'(done_count - base_d), 1);

    // Reset in the middle of a load, then restart.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) beat(k, 8'(k + 200));
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("arst_wr_en", 32'(wr_en_bram), 0);
    chk("arst_addr1", 32'(wr_addr_bram[1]), 0);
    chk("arst_data1", 32'(wr_data_bram[1]), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_idle_wr_en", 32'(wr_en_bram), 0);
      chk("arst_idle_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beat(0, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_write_m1.md
MEM_WRITE_M1 -- requirements
Module: mem_write_m1

Interface
REQ-001 Parameter D_W, default 8, SHALL set element data width in bits.
REQ-002 Parameter N, default 3, SHALL set the number of BRAM banks (systolic array lanes).
REQ-003 Parameter M, default 6, SHALL set the matrix dimension (M x M elements); M SHALL be a multiple of N.
REQ-004 Derived AW SHALL equal $clog2((M*M)/N), the per-bank address width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle request to begin loading a matrix.
REQ-008 in_valid  input  1  element beat valid.
REQ-009 in_data  input  D_W  element value, row-major order.
REQ-010 in_ready  output  1  writer accepts a beat this cycle.
REQ-011 wr_addr_bram  output  N x AW (unpacked [N-1:0])  per-bank write address.
REQ-012 wr_data_bram  output  N x D_W (unpacked [N-1:0])  per-bank write data.
REQ-013 wr_en_bram  output  N  per-bank write enable, at most one bit high per cycle.
REQ-014 busy  output  1  high while not IDLE.
REQ-015 done  output  1  one-cycle pulse marking the final write.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, DONE.
REQ-017 IDLE -> LOAD when start=1; start SHALL be ignored in LOAD and DONE.
REQ-018 in_ready SHALL be 1 exactly when state is LOAD; beat accepted when in_valid & in_ready.
REQ-019 in_valid outside LOAD SHALL have no effect.
REQ-020 Counters row (0..M-1) and col (0..M-1) SHALL start at 0 on entry to LOAD; col increments per accepted beat, wraps to 0 after M-1 and increments row.
REQ-021 Accepted element (row r, col c) SHALL target bank c % N at address (c / N) * M + r, matching the layout the M1 read path fetches.
REQ-022 Write SHALL be registered: wr_en_bram bit, address and data appear exactly one cycle after the accepting edge; unselected banks' wr_en bits SHALL be 0.
REQ-023 Gaps in in_valid during LOAD SHALL stall counters and produce no write in the following cycle.
REQ-024 Accepting beat r=M-1, c=M-1 SHALL move LOAD -> DONE; in DONE the final write is presented and done=1.
REQ-025 DONE -> IDLE unconditionally after one cycle; counters cleared.
REQ-026 Address arithmetic SHALL be computed at full width then truncated to AW; no value exceeds (M*M)/N - 1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, row=col=0, wr_en_bram=0, wr_addr_bram=0, wr_data_bram=0, in_ready=0, busy=0, done=0.
REQ-028 Reset mid-LOAD SHALL abandon the load; no write SHALL issue after reset release until a new start.

Structure
REQ-029 Shared package mem_pkg SHALL hold the FSM state enum and an address-width function used by both the M1 read and write blocks.
REQ-030 Single flat module; no sub-module required.
REQ-031 An elaboration-time check SHALL error when M % N != 0.

Verification (N=3, M=6, D_W=8)
REQ-032 Reset then idle: start=0 -> in_ready=0, wr_en_bram=000, done=0 indefinitely.
REQ-033 start, then 36 back-to-back beats data=k: beat 7 -> wr_en_bram=010, addr[1]=1, data=7 one cycle later; beat 35 -> wr_en_bram=100, addr[2]=11, done=1 same cycle; state IDLE next.
REQ-034 Full load then read via M1 read path: bank b addr c*6+r returns A[r][3c+b] for all 36 entries.
REQ-035 in_valid low 3 cycles after beat 4 -> no wr_en for 3 cycles; beat 5 -> bank 2 addr 6 -> total still 36 writes, one done pulse.
REQ-036 rst_n low after beat 10 -> all outputs 0 asynchronously; new start reloads from row 0 col 0 (first write bank 0 addr 0).
REQ-037 start asserted during LOAD and in_valid in IDLE -> no counter change, no extra writes.
